// File: rtl/fidus_axi4lite_pkg.sv
// Shared types and constants for the fidus AXI4-Lite command master.
package fidus_axi4lite_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WADDR,
    ST_WLAT,
    ST_WRESP,
    ST_RADDR,
    ST_RLAT,
    ST_RRESP,
    ST_DONE
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic logic resp_err(input logic [1:0] resp, input logic chk_en);
    logic bad;
    unique case (resp)
      OKAY:                   bad = 1'b0;
      EXOKAY, SLVERR, DECERR: bad = 1'b1;
      default:                bad = 1'b1;
    endcase
    return bad && chk_en;
  endfunction

endpackage

// File: rtl/fidus_axi4lite_cnt.sv
// Loadable saturating down-counter; flags the last counted cycle (count == 1).
module fidus_axi4lite_cnt
  import fidus_axi4lite_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         at_one
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign at_one = (count == W'(1));

endmodule

// File: rtl/fidus_axi4lite_mst.sv
// AXI4-Lite master: one single-beat read or write per command, with
// configurable response-ready latency, response checking and timeouts.
module fidus_axi4lite_mst
  import fidus_axi4lite_pkg::*;
#(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned LATW   = 8,
  parameter int unsigned TOW    = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AWIDTH-1:0]     cmd_addr,
  input  logic [DWIDTH-1:0]     cmd_wdata,
  input  logic [DWIDTH/8-1:0]   cmd_wstrb,
  output logic                  rsp_valid,
  output logic [DWIDTH-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  input  logic                  cfg_wr_err_chk,
  input  logic                  cfg_rd_err_chk,
  input  logic [LATW-1:0]       cfg_bready_lat,
  input  logic [LATW-1:0]       cfg_rready_lat,
  input  logic [TOW-1:0]        cfg_wr_timeout,
  input  logic [TOW-1:0]        cfg_rd_timeout,
  output logic [AWIDTH-1:0]     awaddr,
  output logic                  awvalid,
  output logic [DWIDTH-1:0]     wdata,
  output logic [DWIDTH/8-1:0]   wstrb,
  output logic                  wvalid,
  output logic                  bready,
  output logic [AWIDTH-1:0]     araddr,
  output logic                  arvalid,
  output logic                  rready,
  input  logic                  awready,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  input  logic                  arready,
  input  logic [DWIDTH-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid
);

  state_t state, state_nxt;

  logic              awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic [DWIDTH-1:0] rsp_rdata_nxt;
  logic [1:0]        rsp_resp_nxt;
  logic              rsp_err_nxt, rsp_timeout_nxt;
  logic              accept, tmo;
  logic              lat_load, lat_one, to_load, to_hit;
  logic [LATW-1:0]   lat_val;
  logic [TOW-1:0]    to_val;

  fidus_axi4lite_cnt #(.W(LATW)) u_lat_cnt (
    .clk      (aclk),
    .rst      (areset),
    .load     (lat_load),
    .load_val (lat_val),
    .dec      ((state == ST_WLAT) || (state == ST_RLAT)),
    .at_one   (lat_one)
  );

  fidus_axi4lite_cnt #(.W(TOW)) u_to_cnt (
    .clk      (aclk),
    .rst      (areset),
    .load     (to_load),
    .load_val (to_val),
    .dec      ((state != ST_IDLE) && (state != ST_DONE)),
    .at_one   (to_hit)
  );

  // A completing handshake is checked before the timeout in every waiting
  // state, so a handshake landing on the expiry cycle wins. WLAT has no
  // handshake, so expiry there always aborts.
  always_comb begin
    state_nxt       = state;
    awvalid_nxt     = awvalid;
    wvalid_nxt      = wvalid;
    bready_nxt      = bready;
    arvalid_nxt     = arvalid;
    rready_nxt      = rready;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_resp_nxt    = rsp_resp;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;
    accept          = 1'b0;
    tmo             = 1'b0;
    lat_load        = 1'b0;
    lat_val         = '0;
    to_load         = 1'b0;
    to_val          = '0;

    unique case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept  = 1'b1;
          to_load = 1'b1;
          if (cmd_write) begin
            to_val      = cfg_wr_timeout;
            state_nxt   = ST_WADDR;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
          end else begin
            to_val      = cfg_rd_timeout;
            state_nxt   = ST_RADDR;
            arvalid_nxt = 1'b1;
          end
        end
      end

      ST_WADDR: begin
        if (awvalid && awready) awvalid_nxt = 1'b0;
        if (wvalid && wready)   wvalid_nxt  = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) begin
          if (cfg_bready_lat == '0) begin
            state_nxt  = ST_WRESP;
            bready_nxt = 1'b1;
          end else begin
            state_nxt = ST_WLAT;
            lat_load  = 1'b1;
            lat_val   = cfg_bready_lat;
          end
        end else if (to_hit) begin
          tmo = 1'b1;
        end
      end

      ST_WLAT: begin
        if (to_hit) begin
          tmo = 1'b1;
        end else if (lat_one) begin
          state_nxt  = ST_WRESP;
          bready_nxt = 1'b1;
        end
      end

      ST_WRESP: begin
        if (bvalid && bready) begin
          state_nxt       = ST_DONE;
          bready_nxt      = 1'b0;
          rsp_rdata_nxt   = '0;
          rsp_resp_nxt    = bresp;
          rsp_err_nxt     = resp_err(bresp, cfg_wr_err_chk);
          rsp_timeout_nxt = 1'b0;
        end else if (to_hit) begin
          tmo = 1'b1;
        end
      end

      ST_RADDR: begin
        if (arvalid && arready) begin
          arvalid_nxt = 1'b0;
          if (cfg_rready_lat == '0) begin
            state_nxt  = ST_RRESP;
            rready_nxt = 1'b1;
          end else begin
            state_nxt = ST_RLAT;
            lat_load  = 1'b1;
            lat_val   = cfg_rready_lat;
          end
        end else if (to_hit) begin
          tmo = 1'b1;
        end
      end

      ST_RLAT: begin
        if (to_hit) begin
          tmo = 1'b1;
        end else if (lat_one) begin
          state_nxt  = ST_RRESP;
          rready_nxt = 1'b1;
        end
      end

      ST_RRESP: begin
        if (rvalid && rready) begin
          state_nxt       = ST_DONE;
          rready_nxt      = 1'b0;
          rsp_rdata_nxt   = rdata;
          rsp_resp_nxt    = rresp;
          rsp_err_nxt     = resp_err(rresp, cfg_rd_err_chk);
          rsp_timeout_nxt = 1'b0;
        end else if (to_hit) begin
          tmo = 1'b1;
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase

    if (tmo) begin
      state_nxt       = ST_DONE;
      awvalid_nxt     = 1'b0;
      wvalid_nxt      = 1'b0;
      bready_nxt      = 1'b0;
      arvalid_nxt     = 1'b0;
      rready_nxt      = 1'b0;
      rsp_rdata_nxt   = '0;
      rsp_resp_nxt    = SLVERR;
      rsp_err_nxt     = 1'b1;
      rsp_timeout_nxt = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state       <= ST_IDLE;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      awvalid     <= 1'b0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready   <= (state_nxt == ST_IDLE);
      rsp_valid   <= (state_nxt == ST_DONE);
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_resp    <= rsp_resp_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
      awvalid     <= awvalid_nxt;
      wvalid      <= wvalid_nxt;
      bready      <= bready_nxt;
      arvalid     <= arvalid_nxt;
      rready      <= rready_nxt;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awaddr <= '0;
      wdata  <= '0;
      wstrb  <= '0;
      araddr <= '0;
    end else if (accept) begin
      if (cmd_write) begin
        awaddr <= cmd_addr;
        wdata  <= cmd_wdata;
        wstrb  <= cmd_wstrb;
      end else begin
        araddr <= cmd_addr;
      end
    end
  end

endmodule

// File: tb/tb_fidus_axi4lite_mst.sv
// Bench for fidus_axi4lite_mst: directed vector table, reset sequences and
// random transactions scored against a cycle-count model of the protocol.
module tb_fidus_axi4lite_mst;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int SW = 2;
  localparam int LW = 8;
  localparam int TW = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          cfg_wr_err_chk, cfg_rd_err_chk;
  logic [LW-1:0] cfg_bready_lat, cfg_rready_lat;
  logic [TW-1:0] cfg_wr_timeout, cfg_rd_timeout;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [SW-1:0] wstrb;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;

  fidus_axi4lite_mst #(.AWIDTH(AW), .DWIDTH(DW), .LATW(LW), .TOW(TW)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .cfg_wr_err_chk(cfg_wr_err_chk), .cfg_rd_err_chk(cfg_rd_err_chk),
    .cfg_bready_lat(cfg_bready_lat), .cfg_rready_lat(cfg_rready_lat),
    .cfg_wr_timeout(cfg_wr_timeout), .cfg_rd_timeout(cfg_rd_timeout),
    .awaddr(awaddr), .awvalid(awvalid), .wdata(wdata), .wstrb(wstrb),
    .wvalid(wvalid), .bready(bready), .araddr(araddr), .arvalid(arvalid),
    .rready(rready), .awready(awready), .wready(wready), .bresp(bresp),
    .bvalid(bvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid)
  );

  always #5 aclk = ~aclk;

  // Cycle numbers are counted from the accepting edge: cycle 1 is the first
  // cycle after it. da/dw: cycles of ready delay; db: response delay after
  // ready rises; e_* fields are the expected observations (0 = never).
  typedef struct {
    int wr, addr, data, strb, da, dw, lat, db, tmo, resp, rdata, chk, noresp;
    int e_av, e_wv, e_rise, e_rlast, e_rsp, e_resp, e_err, e_to, e_rdata;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t tab[11];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int wr, addr, data, strb, da, dw, lat, db, tmo,
                              resp, rdata, chk, noresp, e_av, e_wv, e_rise,
                              e_rlast, e_rsp, e_resp, e_err, e_to, e_rdata);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.da = da; v.dw = dw;
    v.lat = lat; v.db = db; v.tmo = tmo; v.resp = resp; v.rdata = rdata;
    v.chk = chk; v.noresp = noresp; v.e_av = e_av; v.e_wv = e_wv;
    v.e_rise = e_rise; v.e_rlast = e_rlast; v.e_rsp = e_rsp; v.e_resp = e_resp;
    v.e_err = e_err; v.e_to = e_to; v.e_rdata = e_rdata;
    return v;
  endfunction

  // Reference: address phase ends when the slower ready arrives, ready rises
  // one cycle later plus latency, response lands db cycles after that. A
  // nonzero timeout T aborts at cycle T unless a completing handshake is in
  // that same cycle (the address phase or the response).
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int a, rise, hs;
    bit to;
    r    = v;
    a    = 1 + ((v.wr != 0 && v.dw > v.da) ? v.dw : v.da);
    rise = a + 1 + v.lat;
    hs   = (v.noresp != 0) ? 1000000 : rise + v.db;
    to   = (v.tmo != 0) && (v.tmo < hs) && (v.tmo != a);
    r.e_av = (to && v.tmo < 1 + v.da) ? v.tmo : 1 + v.da;
    r.e_wv = (v.wr == 0) ? 0 : ((to && v.tmo < 1 + v.dw) ? v.tmo : 1 + v.dw);
    if (to) begin
      r.e_rise  = (rise <= v.tmo) ? rise : 0;
      r.e_rlast = (rise <= v.tmo) ? v.tmo : 0;
      r.e_rsp   = v.tmo + 1;
      r.e_resp  = 2;
      r.e_err   = 1;
      r.e_to    = 1;
      r.e_rdata = 0;
    end else begin
      r.e_rise  = rise;
      r.e_rlast = hs;
      r.e_rsp   = hs + 1;
      r.e_resp  = v.resp;
      r.e_err   = (v.resp != 0 && v.chk != 0) ? 1 : 0;
      r.e_to    = 0;
      r.e_rdata = (v.wr != 0) ? 0 : v.rdata;
    end
    return r;
  endfunction

  task automatic clear_slave();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int av_last, wv_last, rdy_first, rdy_last, rsp_k, rsp_n;
    int got_resp, got_err, got_to, got_rdata, bus_addr, bus_data, bus_strb;
    int busy_ready, after_ready, hold_resp;
    bit rdy, resp_on, hs_done;
    av_last = 0; wv_last = 0; rdy_first = 0; rdy_last = 0; rsp_k = 0; rsp_n = 0;
    got_resp = -1; got_err = -1; got_to = -1; got_rdata = -1;
    bus_addr = -1; bus_data = -1; bus_strb = -1;
    busy_ready = 0; after_ready = -1; hold_resp = -1; hs_done = 1'b0;

    @(negedge aclk);
    cmd_valid = 1'b1;
    cmd_write = (v.wr != 0);
    cmd_addr  = v.addr[AW-1:0];
    cmd_wdata = v.data[DW-1:0];
    cmd_wstrb = v.strb[SW-1:0];
    // Unused-direction config set to distinct values so a mixed-up select shows.
    cfg_wr_timeout = (v.wr != 0) ? v.tmo[TW-1:0] : ((v.tmo == 0) ? TW'(2) : '0);
    cfg_rd_timeout = (v.wr == 0) ? v.tmo[TW-1:0] : ((v.tmo == 0) ? TW'(2) : '0);
    cfg_bready_lat = (v.wr != 0) ? v.lat[LW-1:0] : LW'(5);
    cfg_rready_lat = (v.wr == 0) ? v.lat[LW-1:0] : LW'(5);
    cfg_wr_err_chk = (v.wr != 0) ? (v.chk != 0) : (v.chk == 0);
    cfg_rd_err_chk = (v.wr == 0) ? (v.chk != 0) : (v.chk == 0);

    for (int k = 1; k <= 200; k++) begin
      @(negedge aclk);
      if (k == 1) cmd_valid = 1'b0;
      if ((v.wr != 0) ? awvalid : arvalid) begin
        if (av_last == 0) begin
          bus_addr = (v.wr != 0) ? int'(awaddr) : int'(araddr);
          bus_data = int'(wdata);
          bus_strb = int'(wstrb);
        end
        av_last = k;
      end
      if (wvalid) wv_last = k;
      rdy = (v.wr != 0) ? bready : rready;
      if (rdy) begin
        if (rdy_first == 0) rdy_first = k;
        rdy_last = k;
      end
      if (rsp_k == 0 && cmd_ready) busy_ready++;
      if (rsp_valid) begin
        rsp_n++;
        if (rsp_k == 0) begin
          rsp_k     = k;
          got_resp  = int'(rsp_resp);
          got_err   = int'(rsp_err);
          got_to    = int'(rsp_timeout);
          got_rdata = int'(rsp_rdata);
        end
      end
      if (rsp_k != 0 && k == rsp_k + 1) begin
        after_ready = int'(cmd_ready);
        hold_resp   = int'(rsp_resp);
        break;
      end
      awready = (v.wr != 0) && (k >= 1 + v.da);
      wready  = (v.wr != 0) && (k >= 1 + v.dw);
      arready = (v.wr == 0) && (k >= 1 + v.da);
      resp_on = (rdy_first != 0) && (v.noresp == 0) && !hs_done && (k >= rdy_first + v.db);
      bvalid  = (v.wr != 0) && resp_on;
      rvalid  = (v.wr == 0) && resp_on;
      bresp   = v.resp[1:0];
      rresp   = v.resp[1:0];
      rdata   = v.rdata[DW-1:0];
      if (resp_on && rdy) hs_done = 1'b1;
    end
    clear_slave();

    check({tag, " addr_valid_last"}, av_last, v.e_av);
    check({tag, " wvalid_last"}, wv_last, v.e_wv);
    check({tag, " ready_rise"}, rdy_first, v.e_rise);
    check({tag, " ready_last"}, rdy_last, v.e_rlast);
    check({tag, " rsp_cycle"}, rsp_k, v.e_rsp);
    check({tag, " rsp_pulses"}, rsp_n, 1);
    check({tag, " rsp_resp"}, got_resp, v.e_resp);
    check({tag, " rsp_err"}, got_err, v.e_err);
    check({tag, " rsp_timeout"}, got_to, v.e_to);
    check({tag, " rsp_rdata"}, got_rdata, v.e_rdata);
    check({tag, " bus_addr"}, bus_addr, v.addr);
    if (v.wr != 0) begin
      check({tag, " bus_wdata"}, bus_data, v.data);
      check({tag, " bus_wstrb"}, bus_strb, v.strb);
    end
    check({tag, " cmd_ready_busy"}, busy_ready, 0);
    check({tag, " cmd_ready_after"}, after_ready, 1);
    check({tag, " rsp_resp_hold"}, hold_resp, v.e_resp);
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    int a;
    v.wr     = int'($urandom_range(0, 1));
    v.addr   = int'($urandom_range(0, 255));
    v.data   = int'($urandom_range(0, 65535));
    v.strb   = int'($urandom_range(0, 3));
    v.da     = int'($urandom_range(0, 4));
    v.dw     = int'($urandom_range(0, 4));
    v.lat    = int'($urandom_range(0, 3));
    v.db     = int'($urandom_range(0, 4));
    v.resp   = int'($urandom_range(0, 3));
    v.rdata  = int'($urandom_range(0, 65535));
    v.chk    = int'($urandom_range(0, 1));
    v.tmo    = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 14)) : 0;
    v.noresp = (v.tmo != 0 && $urandom_range(0, 4) == 0) ? 1 : 0;
    a = 1 + ((v.wr != 0 && v.dw > v.da) ? v.dw : v.da);
    if (v.noresp != 0 && v.tmo == a) v.tmo = a + 1;
    return model(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, seen, outs;
    //          wr addr   data   strb da dw lat db tmo resp rdata  chk nr  av wv rise rl rsp resp err to rdata
    tab[0]  = mk(1, 'h0F, 'hABAB, 3, 0, 0, 0, 4,  0, 0, 0,       0, 0,  1, 1, 2,  6,  7, 0, 0, 0, 0);
    tab[1]  = mk(0, 'hAA, 0,      0, 0, 0, 0, 4,  0, 0, 'h1234,  0, 0,  1, 0, 2,  6,  7, 0, 0, 0, 'h1234);
    tab[2]  = mk(1, 'h31, 'h5A5A, 1, 3, 0, 0, 0,  0, 0, 0,       0, 0,  4, 1, 5,  5,  6, 0, 0, 0, 0);
    tab[3]  = mk(0, 'h40, 0,      0, 0, 0, 2, 0,  0, 2, 'hBEEF,  1, 0,  1, 0, 4,  4,  5, 2, 1, 0, 'hBEEF);
    tab[4]  = mk(1, 'h10, 'h1111, 3, 0, 0, 0, 0, 16, 0, 0,       0, 1,  1, 1, 2, 16, 17, 2, 1, 1, 0);
    tab[5]  = mk(1, 'h22, 'h2222, 2, 0, 0, 1, 0,  0, 2, 0,       0, 0,  1, 1, 3,  3,  4, 2, 0, 0, 0);
    tab[6]  = mk(1, 'h33, 'h3333, 3, 1, 2, 0, 1,  0, 3, 0,       1, 0,  2, 3, 4,  5,  6, 3, 1, 0, 0);
    tab[7]  = mk(0, 'h44, 0,      0, 5, 0, 0, 0,  3, 0, 'h4444,  0, 0,  3, 0, 0,  0,  4, 2, 1, 1, 0);
    tab[8]  = mk(0, 'h55, 0,      0, 1, 0, 0, 0,  2, 1, 'h5555,  1, 0,  2, 0, 3,  3,  4, 1, 1, 0, 'h5555);
    tab[9]  = mk(1, 'h66, 'h6666, 3, 0, 0, 3, 0,  4, 0, 0,       0, 0,  1, 1, 0,  0,  5, 2, 1, 1, 0);
    tab[10] = mk(1, 'h77, 'h7777, 3, 0, 0, 3, 0,  5, 0, 0,       0, 0,  1, 1, 5,  5,  6, 0, 0, 0, 0);

    areset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    cfg_wr_err_chk = 1'b0; cfg_rd_err_chk = 1'b0;
    cfg_bready_lat = '0; cfg_rready_lat = '0; cfg_wr_timeout = '0; cfg_rd_timeout = '0;
    clear_slave();
    repeat (3) @(negedge aclk);

    outs = int'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_timeout});
    check("reset valid_ready_flags", outs, 0);
    check("reset cmd_ready", int'(cmd_ready), 1);
    check("reset rsp_resp", int'(rsp_resp), 0);
    check("reset rsp_rdata", int'(rsp_rdata), 0);
    check("reset awaddr", int'(awaddr), 0);
    areset = 1'b0;
    @(negedge aclk);

    for (int i = 0; i < 11; i++) begin
      run_txn(tab[i], $sformatf("vec%0d", i));
      repeat (2) @(negedge aclk);
    end

    // Reset while waiting in the write response phase.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h5C; cmd_wdata = 16'hC0DE;
    cmd_wstrb = 2'b11; cfg_bready_lat = '0; cfg_wr_timeout = '0;
    awready = 1'b1; wready = 1'b1;
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge aclk);
      if (k == 1) cmd_valid = 1'b0;
      if (bready) begin
        seen = k;
        break;
      end
    end
    check("rstmid bready_seen", seen, 2);
    areset = 1'b1;
    #1;
    outs = int'({awvalid, wvalid, bready, arvalid, rready, rsp_valid});
    check("rstmid axi_outputs", outs, 0);
    check("rstmid cmd_ready", int'(cmd_ready), 1);
    @(negedge aclk);
    areset = 1'b0;
    clear_slave();
    n = 0;
    repeat (6) begin
      @(negedge aclk);
      if (rsp_valid) n++;
    end
    check("rstmid no_rsp", n, 0);
    run_txn(tab[1], "rstmid_read");
    repeat (2) @(negedge aclk);

    for (int i = 0; i < 40; i++) begin
      run_txn(rand_vec(), $sformatf("rnd%0d", i));
      repeat (int'($urandom_range(1, 3))) @(negedge aclk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
